// File: rtl/cordic_ctrl_pkg.sv
// Shared definitions for the CORDIC operator-entry controller and its function units:
// state encoding, default operand-count table and function codes.
package cordic_ctrl_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_ENTER  = 3'd2,
        ST_READY  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_e;

    // Two bits per function code holding its operand count; 0 marks an unsupported code.
    localparam logic [31:0] OPS_TABLE_DEFAULT = 32'h5555_955A;

    localparam int unsigned FUNC_CODE_W = 4;

    localparam logic [FUNC_CODE_W-1:0] FN_ARCTAN = 4'd0;
    localparam logic [FUNC_CODE_W-1:0] FN_SINH   = 4'd2;
    localparam logic [FUNC_CODE_W-1:0] FN_ARCSIN = 4'd3;
    localparam logic [FUNC_CODE_W-1:0] FN_ATANH  = 4'd4;
    localparam logic [FUNC_CODE_W-1:0] FN_EX     = 4'd5;
    localparam logic [FUNC_CODE_W-1:0] FN_LN     = 4'd6;

endpackage

// File: rtl/cordic_entry_sequencer_debouncer.sv
// Push-button conditioner: multi-stage synchroniser followed by a stable-count debouncer.
// Produces the debounced level and a one-cycle pulse on its rising edge.
module button_debouncer #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   btn_s;

    assign btn_s = sync_q[SYNC_STAGES-1];

    // Count consecutive samples disagreeing with the accepted level; any agreement restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (btn_s != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = btn_s;
                rise_d  = btn_s;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/cordic_entry_sequencer.sv
// Operator-entry and compute sequencer: one button walks through function select,
// operand entry, compute start, done/timeout wait and result hold.
module cordic_entry_sequencer
    import cordic_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W          = 16,
    parameter int unsigned FUNC_W          = 4,
    parameter int unsigned MAX_OPS         = 3,
    parameter int unsigned RESULT_W        = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 50000000,
    parameter int unsigned TIMEOUT_CYCLES  = 4096,
    parameter logic [(2<<FUNC_W)-1:0] OPS_TABLE = OPS_TABLE_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        st_btn,
    input  logic [DATA_W-1:0]           sw_in,
    input  logic                        done_i,
    input  logic [RESULT_W-1:0]         result_i,
    output logic [FUNC_W-1:0]           func_o,
    output logic [MAX_OPS*DATA_W-1:0]   op_o,
    output logic                        start_o,
    output logic                        busy_o,
    output logic [RESULT_W-1:0]         result_o,
    output logic                        result_valid_o,
    output logic                        err_o,
    output logic [STATE_W-1:0]          state_o,
    output logic                        idle_o
);

    localparam int unsigned IDX_W = (MAX_OPS > 1) ? $clog2(MAX_OPS + 1) : 1;
    localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_e                           state_q, state_d;
    logic [FUNC_W-1:0]                func_q, func_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [MAX_OPS-1:0][DATA_W-1:0]   op_q, op_d;
    logic [TMR_W-1:0]                 timer_q, timer_d;
    logic [RESULT_W-1:0]              result_q, result_d;
    logic                             start_q, start_d;
    logic                             busy_q, busy_d;
    logic                             idle_q, idle_d;
    logic                             err_q, err_d;
    logic                             rv_q, rv_d;
    logic                             press;
    logic                             btn_level;
    logic [FUNC_W-1:0]                sw_func;
    logic [1:0]                       n_sel, n_cur;
    logic                             sel_ok;
    logic                             last_op;

    button_debouncer #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (st_btn),
        .level_o(btn_level),
        .rise_o (press)
    );

    assign sw_func = sw_in[FUNC_W-1:0];
    assign n_sel   = OPS_TABLE[{sw_func, 1'b0} +: 2];
    assign n_cur   = OPS_TABLE[{func_q, 1'b0} +: 2];
    assign sel_ok  = (n_sel != 2'd0) && (32'(n_sel) <= MAX_OPS);
    assign last_op = (32'(idx_q) + 32'd1) == 32'(n_cur);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state plus operand file, timer and result capture.
    always_comb begin
        state_d  = state_q;
        func_d   = func_q;
        idx_d    = idx_q;
        op_d     = op_q;
        timer_d  = timer_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: if (press) state_d = ST_SELECT;
            ST_SELECT: if (press) begin
                func_d  = sw_func;
                idx_d   = '0;
                op_d    = '0;
                state_d = sel_ok ? ST_ENTER : ST_ERROR;
            end
            ST_ENTER: if (press) begin
                for (int i = 0; i < int'(MAX_OPS); i++) begin
                    if (idx_q == IDX_W'(i)) op_d[i] = sw_in;
                end
                if (last_op) state_d = ST_READY;
                else         idx_d   = idx_q + IDX_W'(1);
            end
            ST_READY: if (press) begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            // A completion arriving on the timeout cycle still counts as success.
            ST_WAIT: begin
                if (done_i) begin
                    result_d = result_i;
                    state_d  = ST_DONE;
                end else if (timer_q == TMR_LAST) begin
                    state_d = ST_ERROR;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_DONE, ST_ERROR: if (press) state_d = ST_SELECT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        start_d = (state_q == ST_READY) && press;
        busy_d  = (state_d == ST_WAIT);
        idle_d  = (state_d == ST_IDLE);
        err_d   = (state_d == ST_ERROR);
        rv_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            func_q   <= '0;
            idx_q    <= '0;
            op_q     <= '0;
            timer_q  <= '0;
            result_q <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            idle_q   <= 1'b0;
            err_q    <= 1'b0;
            rv_q     <= 1'b0;
        end else begin
            func_q   <= func_d;
            idx_q    <= idx_d;
            op_q     <= op_d;
            timer_q  <= timer_d;
            result_q <= result_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            idle_q   <= idle_d;
            err_q    <= err_d;
            rv_q     <= rv_d;
        end
    end

    assign func_o         = func_q;
    assign op_o           = op_q;
    assign start_o        = start_q;
    assign busy_o         = busy_q;
    assign result_o       = result_q;
    assign result_valid_o = rv_q;
    assign err_o          = err_q;
    assign state_o        = state_q;
    assign idle_o         = idle_q;

    logic unused_level;
    assign unused_level = btn_level;

endmodule

// File: tb/tb_cordic_entry_sequencer.sv
// Scoreboard bench for cordic_entry_sequencer: randomized entry flows against a table-driven model.
module tb_cordic_entry_sequencer;

    localparam int unsigned DEB     = 4;
    localparam int unsigned TMO     = 16;
    localparam logic [31:0] TABLE   = 32'h5555_951A;
    localparam int          K_NONE  = 0;
    localparam int          K_START = 1;
    localparam int          K_RES   = 2;
    localparam int          K_ERR   = 3;

    typedef struct {
        int          kind;
        logic [3:0]  func;
        logic [47:0] ops;
        logic [31:0] res;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_btn;
    logic [15:0] sw_in;
    logic        done_i;
    logic [31:0] result_i;
    logic [3:0]  func_o;
    logic [47:0] op_o;
    logic        start_o, busy_o, result_valid_o, err_o, idle_o;
    logic [31:0] result_o;
    logic [2:0]  state_o;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t q[$];

    cordic_entry_sequencer #(
        .DATA_W(16), .FUNC_W(4), .MAX_OPS(3), .RESULT_W(32),
        .DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO), .OPS_TABLE(TABLE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .st_btn(st_btn), .sw_in(sw_in),
        .done_i(done_i), .result_i(result_i), .func_o(func_o), .op_o(op_o),
        .start_o(start_o), .busy_o(busy_o), .result_o(result_o),
        .result_valid_o(result_valid_o), .err_o(err_o), .state_o(state_o), .idle_o(idle_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int nops(input logic [3:0] f);
        return int'((TABLE >> (2 * int'(f))) & 32'd3);
    endfunction

    // Monitor: each observed event must match the oldest expected one.
    logic ps = 1'b0, prv = 1'b0, pe = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            ps = 1'b0; prv = 1'b0; pe = 1'b0;
        end else begin
            if (start_o) begin
                chk("start_width", 64'(ps), 64'd0);
                if (!ps) begin
                    if (q.size() > 0) e = q.pop_front(); else e.kind = K_NONE;
                    chk("ev_start_kind", 64'(K_START), 64'(e.kind));
                    chk("start_func", 64'(func_o), 64'(e.func));
                    chk("start_ops", 64'(op_o), 64'(e.ops));
                end
            end
            if (result_valid_o && !prv) begin
                if (q.size() > 0) e = q.pop_front(); else e.kind = K_NONE;
                chk("ev_result_kind", 64'(K_RES), 64'(e.kind));
                chk("result_val", 64'(result_o), 64'(e.res));
            end
            if (err_o && !pe) begin
                if (q.size() > 0) e = q.pop_front(); else e.kind = K_NONE;
                chk("ev_err_kind", 64'(K_ERR), 64'(e.kind));
            end
            ps = start_o; prv = result_valid_o; pe = err_o;
        end
    end

    task automatic press(input logic [15:0] v);
        sw_in  = v;
        st_btn = 1'b1;
        repeat (DEB + 6) @(negedge clk);
        st_btn = 1'b0;
        repeat (DEB + 6) @(negedge clk);
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_func"}, 64'(func_o), 64'd0);
        chk({tag, "_ops"}, 64'(op_o), 64'd0);
        chk({tag, "_start"}, 64'(start_o), 64'd0);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_result"}, 64'(result_o), 64'd0);
        chk({tag, "_rv"}, 64'(result_valid_o), 64'd0);
        chk({tag, "_err"}, 64'(err_o), 64'd0);
        chk({tag, "_state"}, 64'(state_o), 64'd0);
        chk({tag, "_idle"}, 64'(idle_o), 64'd0);
    endtask

    // mode 0: done after d cycles, 1: timeout, 2: reset while waiting.
    task automatic flow(input logic [3:0] f, input logic [15:0] a0, input logic [15:0] a1,
                        input logic [15:0] a2, input int mode, input int d, input logic [31:0] res);
        logic [15:0] ops [3];
        logic [47:0] ov;
        int          n, cnt;
        exp_t        e;
        ops[0] = a0; ops[1] = a1; ops[2] = a2;
        n = nops(f);
        chk("pre_select_state", 64'(state_o), 64'd1);
        if (n == 0 || n > 3) begin
            e.kind = K_ERR; q.push_back(e);
            press({12'($urandom), f});
            chk("unsup_state", 64'(state_o), 64'd6);
            chk("unsup_err", 64'(err_o), 64'd1);
            press(16'($urandom));
            chk("err_exit_state", 64'(state_o), 64'd1);
            chk("err_exit_err", 64'(err_o), 64'd0);
            return;
        end
        press({12'($urandom), f});
        chk("enter_state", 64'(state_o), 64'd2);
        ov = '0;
        for (int i = 0; i < n; i++) begin
            ov[i*16 +: 16] = ops[i];
            press(ops[i]);
            chk("entry_state", 64'(state_o), (i == n - 1) ? 64'd3 : 64'd2);
        end
        e.kind = K_START; e.func = f; e.ops = ov; q.push_back(e);
        sw_in  = 16'($urandom);
        st_btn = 1'b1;
        cnt = 0;
        while (!busy_o && cnt < 40) begin @(negedge clk); cnt++; end
        chk("wait_entered", 64'(busy_o), 64'd1);
        if (mode == 2) begin
            repeat (3) @(negedge clk);
            rst_n = 1'b0; st_btn = 1'b0;
            #1;
            reset_chk("rst_wait");
            @(negedge clk);
            rst_n = 1'b1;
            repeat (DEB + 6) @(negedge clk);
            chk("post_rst_state", 64'(state_o), 64'd0);
            chk("post_rst_idle", 64'(idle_o), 64'd1);
            result_i = 32'hDEAD_BEEF; done_i = 1'b1;
            @(negedge clk); done_i = 1'b0;
            @(negedge clk);
            chk("stray_done_idle_result", 64'(result_o), 64'd0);
            chk("stray_done_idle_rv", 64'(result_valid_o), 64'd0);
            chk("stray_done_idle_state", 64'(state_o), 64'd0);
            press(16'($urandom));
            chk("idle_to_select", 64'(state_o), 64'd1);
            return;
        end
        if (mode == 0) begin
            e.kind = K_RES; e.res = res; q.push_back(e);
            repeat (d) @(negedge clk);
            result_i = res; done_i = 1'b1;
            @(negedge clk);
            done_i = 1'b0; result_i = ~res;
            @(negedge clk);
            chk("done_state", 64'(state_o), 64'd5);
            chk("done_result", 64'(result_o), 64'(res));
            chk("done_rv", 64'(result_valid_o), 64'd1);
            chk("done_busy", 64'(busy_o), 64'd0);
            result_i = res ^ 32'h0000_FFFF; done_i = 1'b1;
            @(negedge clk); done_i = 1'b0;
            @(negedge clk);
            chk("stray_done_hold", 64'(result_o), 64'(res));
        end else begin
            e.kind = K_ERR; q.push_back(e);
            cnt = 0;
            while (!err_o && cnt < 40) begin @(negedge clk); cnt++; end
            chk("timeout_cycles", 64'(cnt), 64'(TMO));
            chk("timeout_state", 64'(state_o), 64'd6);
            chk("timeout_busy", 64'(busy_o), 64'd0);
        end
        st_btn = 1'b0;
        repeat (DEB + 6) @(negedge clk);
        press(16'($urandom));
        chk("back_select_state", 64'(state_o), 64'd1);
        chk("back_select_err", 64'(err_o), 64'd0);
        chk("back_select_rv", 64'(result_valid_o), 64'd0);
        chk("kept_func", 64'(func_o), 64'(f));
        chk("kept_ops", 64'(op_o), 64'(ov));
    endtask

    initial begin
        rst_n = 1'b0; st_btn = 1'b0; sw_in = '0; done_i = 1'b0; result_i = '0;
        repeat (3) @(negedge clk);
        reset_chk("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", 64'(idle_o), 64'd1);
        chk("state_after_reset", 64'(state_o), 64'd0);

        for (int i = 0; i < 10; i++) begin
            st_btn = ~st_btn;
            repeat (2) @(negedge clk);
        end
        chk("bounce_no_press", 64'(state_o), 64'd0);
        st_btn = 1'b1;
        repeat (DEB + 6) @(negedge clk);
        chk("bounce_one_press", 64'(state_o), 64'd1);
        repeat (3 * DEB) @(negedge clk);
        chk("hold_one_press", 64'(state_o), 64'd1);
        st_btn = 1'b0;
        repeat (DEB + 6) @(negedge clk);

        flow(4'd0, 16'h1000, 16'h0800, 16'h0000, 0, 4, 32'h0000_1234);
        flow(4'd2, 16'h2000, 16'h0000, 16'h0000, 0, 2, 32'h0000_5678);
        flow(4'd1, 16'h0123, 16'h0456, 16'h0000, 1, 0, 32'h0);
        flow(4'd3, 16'h1111, 16'h0000, 16'h0000, 0, 0, 32'h0);
        flow(4'd7, 16'h8001, 16'h7FFF, 16'h0000, 0, 15, 32'hCAFE_F00D);
        for (int i = 0; i < 12; i++) begin
            flow(4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom);
        end
        flow(4'd7, 16'h0042, 16'h0043, 16'h0000, 2, 0, 32'h0);
        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cordic_entry_sequencer.md
Name: cordic_entry_sequencer

Overview:
Parametrised operator-entry and compute sequencer for the CORDIC function units. It takes one push-button and a switch bank, and walks the user through entry:
- select a function code;
- enter a per-function number of operands (1..MAX_OPS);
- issue a one-cycle start to the compute units;
- wait for their done handshake (with timeout), then latch the result for the seven-segment driver.

It replaces the fixed two-operand, idle-in-debounce controller with a counter-based debouncer, a table-driven operand count, an error state and a result-valid handshake.

Parameters:
DATA_W, 16, operand width (switch bank width)
FUNC_W, 4, function code width (taken from sw_in[FUNC_W-1:0])
MAX_OPS, 3, maximum operands per function
RESULT_W, 32, result width
DEBOUNCE_CYCLES, 50000000, stable-level cycles before a button change is accepted
TIMEOUT_CYCLES, 4096, max cycles in WAIT before error
OPS_TABLE, 32'h5555_955A, 2 bits per function = operand count. Default: funcs 0,1,7 use 2 operands, all others 1. A count of 0 means unsupported; a count above MAX_OPS is also treated as unsupported.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
st_btn  in  1  raw push-button, asynchronous
sw_in  in  DATA_W  switch bank
done_i  in  1  compute-unit completion pulse/level
result_i  in  RESULT_W  compute-unit result
func_o  out  FUNC_W  latched function code
op_o  out  MAX_OPS*DATA_W  latched operands, op 0 in LSBs, signed
start_o  out  1  one-cycle compute start pulse
busy_o  out  1  high in WAIT
result_o  out  RESULT_W  latched result
result_valid_o  out  1  result_o valid
err_o  out  1  unsupported function or timeout
state_o  out  3  current state encoding, for the display
idle_o  out  1  high in IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs, operand index, timer and debouncer zero.
- Button path:
  - 2-flop synchroniser on st_btn.
  - Debounced level changes only after DEBOUNCE_CYCLES consecutive identical synchronised samples.
  - `press` = 1-cycle pulse on the debounced rising edge. Holding the button gives exactly one press.
  - Press-to-action latency is 2 + DEBOUNCE_CYCLES + 1 cycles from a clean edge.
- State encodings: IDLE=0, SELECT=1, ENTER=2, READY=3, WAIT=4, DONE=5, ERROR=6.
- IDLE: press -> SELECT.
- SELECT: press ->
  - func_o <= sw_in[FUNC_W-1:0]; idx <= 0; all op_o cleared.
  - n = OPS_TABLE[2*func+:2]. If n==0 or n>MAX_OPS -> ERROR with err_o=1, else -> ENTER.
- ENTER: press ->
  - op[idx] <= sw_in.
  - If idx+1==n -> READY, else idx <= idx+1 and stay in ENTER.
  - Unentered operand slots remain 0.
- READY: press -> start_o=1 for exactly the transition cycle; timer <= 0; -> WAIT.
- WAIT:
  - busy_o=1 and presses are ignored.
  - done_i -> result_o <= result_i, result_valid_o <= 1, -> DONE.
  - Otherwise the timer increments. At timer==TIMEOUT_CYCLES-1 without done_i -> ERROR, err_o=1.
  - done_i in the same cycle as the timeout: done wins.
- DONE: result held. Press -> result_valid_o <= 0, -> SELECT; func_o and op_o are kept until the next SELECT press.
- ERROR: press -> err_o <= 0, -> SELECT.
- done_i outside WAIT is ignored; result_o does not change.
- Timer and idx widths are clog2-sized. The timer saturates and does not wrap.
- Async reset mid-WAIT: return to IDLE immediately. start_o is never re-issued without a fresh READY press.

Decomposition:
- Shared package cordic_ctrl_pkg holds: the state encoding constants; the default OPS_TABLE constant; a function-code constant list shared with the arctan/arcsin/sinh/atanh/ex/ln units.
- One sub-module, button_debouncer (params SYNC_STAGES=2, DEBOUNCE_CYCLES), outputs the level and the rising-edge pulse.
- The FSM, operand register file and timer stay in cordic_entry_sequencer.

Test Plan:
- Bench uses DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=16.
1. Two-operand flow:
   - Stimulus: presses with sw_in=0x0000 (select func 0), 0x1000, 0x0800, then a READY press; done_i 5 cycles after start with result_i=0x0000_1234.
   - Expect: op_o={0,0x0800,0x1000}, exactly one start_o pulse, result_o=0x1234, result_valid_o=1, state_o=5.
2. One-operand flow:
   - Stimulus: func 2, operand 0x2000, READY press.
   - Expect: ENTER -> READY after a single operand; op_o[31:16]=0; start_o asserted once.
3. Bounce rejection:
   - Stimulus: st_btn toggles every 2 cycles for 20 cycles, then held high.
   - Expect: exactly one press and one state advance.
4. Timeout:
   - Stimulus: no done_i after start.
   - Expect: ERROR with err_o=1 after 16 WAIT cycles. Next press -> SELECT with err_o=0.
5. Unsupported function:
   - Stimulus: OPS_TABLE entry for func 3 overridden to 0, select func 3.
   - Expect: ERROR, no start_o.
6. Reset mid-WAIT, plus done_i outside WAIT:
   - Stimulus: rst_n low for 1 cycle during WAIT; later, done_i pulsed while in IDLE.
   - Expect: all outputs 0 and state_o=0; result_o unchanged by the stray done_i.
